// File: rtl/spi_word_sequencer.sv
// Feeds 24-bit command words from a small FIFO to the SPI transmitter, one word per done_send handshake.
// Optional watchdog: define SPI_SEQ_TIMEOUT_EN to abort a stuck word after TIMEOUT_CYCLES.
module spi_word_sequencer #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_div,
    input  logic                     rst_n,
    input  logic [23:0]              wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [23:0]              tx_data,
    output logic                     tx_load,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              words_sent,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

    state_t          state, state_nxt;
    logic [23:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic [23:0]     tx_data_q;
    logic [15:0]     sent_cnt;
    logic            busy_q;
    logic            push, pop, done_evt, to_evt;

    assign wr_ready   = (count != FULL_LVL);
    assign push       = wr_valid && wr_ready;
    // Pop reads the registered count, so a word written this edge cannot issue until the next.
    assign pop        = (state == IDLE) && (count != '0) && tx_done;
    assign done_evt   = (state == WAIT_DONE) && tx_done;
    assign level      = count;
    assign tx_data    = tx_data_q;
    assign words_sent = sent_cnt;
    assign busy       = busy_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WW = ($clog2(TIMEOUT_CYCLES+1) > 8) ? $clog2(TIMEOUT_CYCLES+1) : 8;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES-1);

    logic [WW-1:0] wdog;
    logic          err_q;

    // Fires only when no normal handshake transition is taken this cycle.
    assign to_evt = (wdog == WD_LAST) &&
                    (((state == LOAD) && tx_done) || ((state == WAIT_DONE) && !tx_done));
    assign timeout_err = err_q;

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_nxt != state)
                wdog <= '0;
            else if (state != IDLE)
                wdog <= wdog + 1'b1;
            if (err_clr)
                err_q <= 1'b0;
            else if (to_evt)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = &{1'b0, err_clr, TIMEOUT_CYCLES[0]};
    assign to_evt      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = LOAD;
            LOAD:      if (!tx_done) state_nxt = WAIT_DONE;
                       else if (to_evt) state_nxt = IDLE;
            WAIT_DONE: if (tx_done) state_nxt = IDLE;
                       else if (to_evt) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tx_load = (state == LOAD);
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage has no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk_div) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tx_data_q <= '0;
            sent_cnt  <= '0;
            busy_q    <= 1'b0;
        end else begin
            count  <= count_nxt;
            busy_q <= (count_nxt != '0) || (state_nxt != IDLE);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_q <= mem[rd_ptr];
            end
            if (done_evt)
                sent_cnt <= sent_cnt + 1'b1;
        end
    end

endmodule

// File: doc/spi_word_sequencer.md
# spi_word_sequencer

Upstream feeder for the 24-bit SPI transmitter stage. It buffers 24-bit command words from the control logic in a small FIFO. It presents them one at a time on the transmitter's `data_in`/`load_data` inputs and paces issue on the transmitter's `done_send` handshake. It runs entirely in the `clk_div` domain, the same clock as the transmitter.

## Interface
- `DEPTH`, 8: FIFO depth in words; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 255: watchdog limit in clk_div cycles; used only when `SPI_SEQ_TIMEOUT_EN` is defined.

- `clk_div` in 1: sequencer and FIFO clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_data` in 24: word to enqueue.
- `wr_valid` in 1: enqueue request.
- `wr_ready` out 1: FIFO not full.
- `tx_data` out 24: drives transmitter `data_in`.
- `tx_load` out 1: drives transmitter `load_data`.
- `tx_done` in 1: from transmitter `done_send`; 1 = idle/complete.
- `busy` out 1: FIFO non-empty or state ≠ IDLE.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `words_sent` out 16: completed-word counter; wraps 0xFFFF→0.
- `timeout_err` out 1: sticky watchdog flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- FIFO: circular buffer with pointers of $clog2(DEPTH) bits and a count register.
  - `wr_ready = (level != DEPTH)`, combinational from the registered count.
  - Write occurs when `wr_valid && wr_ready`. `wr_valid` while full is ignored; no overwrite.
  - No write-through: a word written into an empty FIFO is first visible the next cycle.
  - A simultaneous write and pop leaves `level` unchanged.
- FSM states: IDLE, LOAD, WAIT_DONE.
  - IDLE → LOAD when `level != 0 && tx_done == 1`. On that edge: `tx_data` ← FIFO head, pop, `tx_load` ← 1.
  - LOAD: hold `tx_load = 1` and `tx_data` stable. When `tx_done == 0` is sampled, set `tx_load` ← 0 and go to WAIT_DONE.
  - WAIT_DONE: when `tx_done == 1` is sampled, increment `words_sent` and go to IDLE.
- `tx_data` holds its last value outside LOAD.
- `err_clr` has priority over a same-cycle timeout set; the result is `timeout_err` = 0.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents are discarded (pointers and count = 0). The transmitter is reset by the same `rst_n`.

## Timing
- Reset values:
  - `tx_load`=0, `tx_data`=0, `level`=0, `wr_ready`=1, `busy`=0, `words_sent`=0, `timeout_err`=0, state=IDLE.
- Latency: word written at edge N into an empty FIFO with `tx_done`=1 → `tx_load` high after edge N+1.
- After `tx_done` falls: `tx_load` drops one edge after `tx_done` is sampled low.
- Back-to-back: the next word issues on the edge after `tx_done` is sampled high in WAIT_DONE, giving at least one IDLE cycle between words.
- `busy` is registered: high the cycle after the first write, low the cycle after the return to IDLE with an empty FIFO.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - An 8+-bit watchdog counter is cleared on entry to LOAD or WAIT_DONE and increments each cycle in those states.
  - When it reaches `TIMEOUT_CYCLES`: `tx_load` ← 0, `timeout_err` ← 1, state ← IDLE.
  - The word is dropped and `words_sent` is not incremented.
- Not defined:
  - No watchdog logic; the sequencer waits indefinitely.
  - `timeout_err` is tied to 0 and `err_clr` is ignored.

## Test plan
- Single word: reset, `tx_done`=1, write 0xA5C3F0.
  - `tx_load` rises 1 cycle after the write, with `tx_data`=0xA5C3F0.
  - Transmitter model drops `tx_done` → `tx_load` falls next edge.
  - `tx_done` rises → `words_sent`=1, `busy`=0.
- Fill/full: write 9 words with `DEPTH`=8 and `tx_done` held 0.
  - `level`=8 and `wr_ready`=0 after the 8th write.
  - The 9th write is ignored.
  - Release `tx_done`: words drain in order 1..8 and `words_sent`=8.
- Simultaneous write/pop: with `level`=3, write on the IDLE→LOAD edge → `level` stays 3.
- Reset mid-LOAD: assert `rst_n`=0 while `tx_load`=1 with 4 queued.
  - Immediately `tx_load`=0, `level`=0, `words_sent`=0.
  - After release, nothing is issued until a new write.
- Timeout (macro on, `TIMEOUT_CYCLES`=20): hold `tx_done`=1 after `tx_load` rises.
  - After 20 cycles: `tx_load`=0, `timeout_err`=1, `words_sent` unchanged.
  - `err_clr` pulse → `timeout_err`=0.
- Counter wrap: preload via 65536 completions (or force) → `words_sent` returns to 0.
